// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller FSM states and the hardwired zero register index.
package pipe_pkg;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_EXALU  = 2'b01,
      FWD_MEMALU = 2'b10,
      FWD_MEMDO  = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// ID-stage forwarding select for one source operand; EX producers win over MEM,
// and r0 (or an operand the instruction does not read) is never forwarded.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [4:0] src,
   input  logic       src_en,
   input  logic       ex_wreg,
   input  logic       ex_m2reg,
   input  logic [4:0] ex_rd_rt,
   input  logic       mem_wreg,
   input  logic       mem_m2reg,
   input  logic [4:0] mem_rd_rt,
   output fwd_sel_t   sel
);

   always_comb begin
      sel = FWD_RF;
      if (src_en && src != REG_ZERO) begin
         // A load still in EX has no data yet; it falls through to the MEM check.
         if (ex_wreg && !ex_m2reg && ex_rd_rt == src)
            sel = FWD_EXALU;
         else if (mem_wreg && mem_rd_rt == src)
            sel = mem_m2reg ? FWD_MEMDO : FWD_MEMALU;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: forwarding selects, load-use stalls,
// taken-branch flushes and the freeze/timeout sequence for slow data memory.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch_taken,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [4:0]       ex_rd_rt,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [4:0]       mem_rd_rt,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             memwb_bubble,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_err
);

   localparam int NUM_OPS = 2;
   localparam int WC_W    = $clog2(MEM_TIMEOUT + 1);

   ctrl_state_t               state, state_nxt;
   logic [WC_W-1:0]           wait_cnt, wait_nxt;
   logic                      err_nxt;
   logic                      load_use;
   logic [NUM_OPS-1:0][4:0]   op_src;
   logic [NUM_OPS-1:0]        op_en;
   fwd_sel_t                  op_sel [NUM_OPS];

   assign op_src = {id_rt, id_rs};
   assign op_en  = {id_uses_rt, 1'b1};

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
      fwd_unit u_fwd (
         .src       (op_src[g]),
         .src_en    (op_en[g]),
         .ex_wreg   (ex_wreg),
         .ex_m2reg  (ex_m2reg),
         .ex_rd_rt  (ex_rd_rt),
         .mem_wreg  (mem_wreg),
         .mem_m2reg (mem_m2reg),
         .mem_rd_rt (mem_rd_rt),
         .sel       (op_sel[g])
      );
   end

   assign fwda = rst ? FWD_RF : op_sel[0];
   assign fwdb = rst ? FWD_RF : op_sel[1];

   assign load_use = ex_wreg && ex_m2reg && ex_rd_rt != REG_ZERO &&
                     (ex_rd_rt == id_rs || (id_uses_rt && ex_rd_rt == id_rt));

   always_comb begin
      state_nxt    = state;
      wait_nxt     = wait_cnt;
      err_nxt      = mem_err;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;

      if (state == ERROR || (mem_req && !dmem_ready && state == RUN) ||
          (state == MEM_WAIT && !dmem_ready)) begin
         // Freeze: only MEM_WB moves, and it takes a bubble.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
         if (state == ERROR) begin
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end else if (id_branch_taken) begin
         ifid_flush = 1'b1;
      end

      unique case (state)
         RUN: if (mem_req && !dmem_ready) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = WC_W'(1);
         end
         MEM_WAIT: if (dmem_ready) begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end else if (wait_cnt >= WC_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
         end else begin
            wait_nxt = wait_cnt + WC_W'(1);
         end
         default: state_nxt = ERROR;
      endcase

      if (rst) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         mem_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         mem_err  <= err_nxt;
         if (!pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each step pushes its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs, id_rt, ex_rd_rt, mem_rd_rt;
   logic id_uses_rt, id_branch_taken, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
   logic mem_req, dmem_ready;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_bubble, memwb_bubble;
   logic [1:0] fwda, fwdb;
   logic [CNT_W-1:0] stall_cnt;
   logic mem_err;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_taken(id_branch_taken),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd_rt(ex_rd_rt),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd_rt(mem_rd_rt),
      .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .memwb_bubble(memwb_bubble),
      .fwda(fwda), .fwdb(fwdb), .stall_cnt(stall_cnt), .mem_err(mem_err)
   );

   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, memwb_bubble}
   localparam logic [7:0] C_RST = 8'b00000_111;
   localparam logic [7:0] C_RUN = 8'b11111_000;
   localparam logic [7:0] C_FLS = 8'b11111_100;
   localparam logic [7:0] C_LU  = 8'b00111_010;
   localparam logic [7:0] C_FRZ = 8'b00001_001;
   localparam logic [7:0] C_ERR = 8'b00000_111;

   typedef struct {
      string            tag;
      logic [7:0]       ctl;
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic [CNT_W-1:0] stalls;
      logic             merr;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0;
   int n_err = 0;
   logic [CNT_W-1:0] exp_stalls = '0;
   wire  [7:0] got_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_bubble, memwb_bubble};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check_eq({e.tag, ".ctl"},   32'(got_ctl),   32'(e.ctl));
         check_eq({e.tag, ".fwda"},  32'(fwda),      32'(e.fa));
         check_eq({e.tag, ".fwdb"},  32'(fwdb),      32'(e.fb));
         check_eq({e.tag, ".stall"}, 32'(stall_cnt), 32'(e.stalls));
         check_eq({e.tag, ".merr"},  32'(mem_err),   32'(e.merr));
      end
   end

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch_taken = 0;
      ex_wreg = 0; ex_m2reg = 0; ex_rd_rt = 0;
      mem_wreg = 0; mem_m2reg = 0; mem_rd_rt = 0;
      mem_req = 0; dmem_ready = 0;
   endtask

   // Inputs are already driven; push expectations, let the monitor compare,
   // then advance the bench's stall count model across the clock edge.
   task automatic step(input string tag, input logic [7:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic merr);
      exp_t e;
      e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.stalls = exp_stalls; e.merr = merr;
      sb.push_back(e);
      @(negedge clk);
      if (rst) exp_stalls = '0;
      else if (!ctl[7] && exp_stalls != '1) exp_stalls = exp_stalls + 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      step("rst0", C_RST, 2'b00, 2'b00, 1'b0);
      step("rst1", C_RST, 2'b00, 2'b00, 1'b0);
      rst = 1'b0;
      step("idle", C_RUN, 2'b00, 2'b00, 1'b0);

      // load-use on rs, then the load reaches MEM and is forwarded from load data
      ex_wreg = 1; ex_m2reg = 1; ex_rd_rt = 5; id_rs = 5;
      step("lu", C_LU, 2'b00, 2'b00, 1'b0);
      idle(); mem_wreg = 1; mem_m2reg = 1; mem_rd_rt = 5; id_rs = 5;
      step("lu_mem", C_RUN, 2'b11, 2'b00, 1'b0);

      // EX priority over MEM; r0 never forwarded
      idle(); ex_wreg = 1; ex_rd_rt = 3; mem_wreg = 1; mem_rd_rt = 3;
      id_rs = 3; id_rt = 0; id_uses_rt = 1;
      step("fwd_ex", C_RUN, 2'b01, 2'b00, 1'b0);
      idle(); mem_wreg = 1; mem_rd_rt = 7; id_rt = 7; id_uses_rt = 1;
      step("fwd_mem", C_RUN, 2'b00, 2'b10, 1'b0);
      id_uses_rt = 0;
      step("fwd_nort", C_RUN, 2'b00, 2'b00, 1'b0);

      // three-cycle memory wait then completion, then single-cycle access stays in RUN
      idle(); mem_req = 1;
      for (int i = 0; i < 3; i++) step($sformatf("wait%0d", i), C_FRZ, 2'b00, 2'b00, 1'b0);
      dmem_ready = 1;
      step("wait_done", C_RUN, 2'b00, 2'b00, 1'b0);
      step("single", C_RUN, 2'b00, 2'b00, 1'b0);

      // load-use masks the branch; branch acts once the hazard clears
      idle(); ex_wreg = 1; ex_m2reg = 1; ex_rd_rt = 9; id_rt = 9; id_uses_rt = 1;
      id_branch_taken = 1;
      step("lu_br", C_LU, 2'b00, 2'b00, 1'b0);
      idle(); id_branch_taken = 1;
      step("br", C_FLS, 2'b00, 2'b00, 1'b0);

      // freeze wins over load-use; on completion the load-use rule applies
      idle(); mem_req = 1; ex_wreg = 1; ex_m2reg = 1; ex_rd_rt = 4; id_rs = 4;
      step("frz_lu", C_FRZ, 2'b00, 2'b00, 1'b0);
      dmem_ready = 1;
      step("done_lu", C_LU, 2'b00, 2'b00, 1'b0);

      // timeout after four stuck cycles, then ERROR ignores dmem_ready
      idle(); mem_req = 1;
      for (int i = 0; i < 4; i++) step($sformatf("to%0d", i), C_FRZ, 2'b00, 2'b00, 1'b0);
      step("err0", C_ERR, 2'b00, 2'b00, 1'b1);
      dmem_ready = 1;
      step("err1", C_ERR, 2'b00, 2'b00, 1'b1);

      // reset forces selects to 00 and clears the sticky error
      idle(); rst = 1; ex_wreg = 1; ex_rd_rt = 3; id_rs = 3;
      step("rst_err", C_RST, 2'b00, 2'b00, 1'b1);
      rst = 0; idle();
      step("post_rst", C_RUN, 2'b00, 2'b00, 1'b0);
      mem_req = 1; dmem_ready = 1;
      step("post_run", C_RUN, 2'b00, 2'b00, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined MIPS core.
- Produces ID-stage forwarding selects, load-use stalls, taken-branch flushes and the freeze sequence for multi-cycle data-memory accesses.
- Drives the enable/bubble inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB; keeps a stall counter and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive wait cycles for dmem_ready before ERROR.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_branch_taken  in  1  branch/jump resolved taken in ID
- ex_wreg, ex_m2reg  in  1 each  ID_EX control outputs
- ex_rd_rt  in  5  destination register in EX
- mem_wreg, mem_m2reg  in  1 each  EX_MEM control outputs
- mem_rd_rt  in  5  destination register in MEM
- mem_req  in  1  load/store present in MEM
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
- ifid_flush  out  1  clear IF_ID to NOP
- idex_bubble  out  1  force ID_EX wreg/m2reg/wmem to 0
- memwb_bubble  out  1  force MEM_WB wreg/m2reg to 0
- fwda, fwdb  out  2 each  ID operand select: 00 regfile, 01 EX alu result, 10 MEM alu result, 11 MEM load data
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
- mem_err  out  1  sticky timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR; state register, wait counter, stall_cnt and mem_err update on posedge clk.
- Reset (rst=1 at posedge): state=RUN, wait counter=0, stall_cnt=0, mem_err=0. While rst is high, all enables=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1, fwda=fwdb=00.
- Forwarding (combinational, all states). Per operand (rs for fwda; rt for fwdb, qualified by id_uses_rt):
  - 01 if ex_wreg & !ex_m2reg & ex_rd_rt==src & src!=0;
  - else 10 if mem_wreg & !mem_m2reg & mem_rd_rt==src & src!=0;
  - else 11 if mem_wreg & mem_m2reg & mem_rd_rt==src & src!=0;
  - else 00. EX match has priority over MEM.
- load_use = ex_wreg & ex_m2reg & ex_rd_rt!=0 & (ex_rd_rt==id_rs | (id_uses_rt & ex_rd_rt==id_rt)).
- RUN, priority order:
  - (a) mem_req & !dmem_ready: freeze. pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_bubble=1. Next state MEM_WAIT, wait counter=1.
  - (b) load_use: pc_en=ifid_en=0, idex_en=1, idex_bubble=1, later stages enabled. id_branch_taken is ignored this cycle and re-evaluated next cycle.
  - (c) id_branch_taken: all enables 1, ifid_flush=1.
  - (d) otherwise all enables 1, no bubble or flush.
- MEM_WAIT:
  - Same freeze outputs as (a) while dmem_ready=0; wait counter increments.
  - dmem_ready=1: apply RUN rules (b)-(d) combinationally this cycle, so MEM_WB captures the completed access. Next state RUN, counter cleared.
  - Counter reaching MEM_TIMEOUT with dmem_ready=0: next state ERROR, mem_err set.
- ERROR: all enables 0, all bubbles 1. Exits only by rst.
- stall_cnt increments every cycle pc_en=0 and rst=0; saturates at all-ones with no wrap.
- Single-cycle memory (dmem_ready=1 whenever mem_req=1) never leaves RUN.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMDO=2'b11);
  - ctrl_state_t enum (RUN, MEM_WAIT, ERROR);
  - REG_ZERO=5'd0.
- One sub-module, fwd_unit: purely combinational forwarding selects for one operand, instantiated twice (rs and rt).

Test Plan:
- rst held 2 cycles, then released with idle inputs -> during reset enables=0 and all bubbles/flush=1; first cycle after reset all enables=1, fwda=fwdb=00, stall_cnt=0.
- ex: lw $5 (wreg=1, m2reg=1, rd_rt=5); id_rs=5 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt=1. Next cycle (load now in MEM) fwda=11, pc_en=1.
- ex: add rd=3 and mem: add rd=3; id_rs=3, id_rt=0 with id_uses_rt=1 -> fwda=01 (EX priority), fwdb=00 (r0 never forwarded).
- mem_req=1, dmem_ready low 3 cycles then high -> 3 frozen cycles with memwb_bubble=1; 4th cycle all enables=1; stall_cnt=3; state back to RUN.
- load_use and id_branch_taken asserted together -> cycle 1: stall, ifid_flush=0. Cycle 2, branch still taken and no hazard: ifid_flush=1.
- MEM_TIMEOUT=4, dmem_ready stuck 0 -> mem_err=1 after the timeout, all enables stay 0 regardless of dmem_ready. rst -> mem_err=0, state RUN.
